// File: rtl/ip_lpm_pkg.sv
// Shared route-entry definitions for the longest-prefix-match lookup stage
// and the register-block glue that manages its table.
package ip_lpm_pkg;

    localparam int IP_WIDTH       = 32;
    localparam int LPM_NUM_QUEUES = 8;

    typedef logic [IP_WIDTH-1:0] ip_addr_t;

    typedef struct packed {
        ip_addr_t                  ip;
        ip_addr_t                  mask;
        ip_addr_t                  next_hop_ip;
        logic [LPM_NUM_QUEUES-1:0] output_port;
    } route_entry_t;

    function automatic logic prefix_match(input ip_addr_t dst,
                                          input ip_addr_t ip,
                                          input ip_addr_t mask);
        return ((dst & mask) == (ip & mask));
    endfunction

endpackage

// File: rtl/lpm_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set request
// bit and a flag saying whether any bit was set.
module lpm_prio_enc #(
    parameter int WIDTH    = 32,
    parameter int IDX_BITS = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    req,
    output logic [IDX_BITS-1:0] idx,
    output logic                found
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_BITS'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_lpm.sv
// Two-stage longest-prefix-match route lookup over a register-resident table,
// with a software read/write port for table maintenance.
module ip_lpm
    import ip_lpm_pkg::*;
#(
    parameter int NUM_QUEUES     = LPM_NUM_QUEUES,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IP_WIDTH-1:0]       dst_ip,
    input  logic                      dst_ip_vld,
    output logic [IP_WIDTH-1:0]       next_hop_ip,
    output logic [NUM_QUEUES-1:0]     lpm_output_port,
    output logic                      lpm_vld,
    output logic                      lpm_hit,
    input  logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
    input  logic                      lpm_rd_req,
    output logic [IP_WIDTH-1:0]       lpm_rd_ip,
    output logic [IP_WIDTH-1:0]       lpm_rd_mask,
    output logic [IP_WIDTH-1:0]       lpm_rd_next_hop_ip,
    output logic [NUM_QUEUES-1:0]     lpm_rd_output_port,
    output logic                      lpm_rd_ack,
    input  logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
    input  logic                      lpm_wr_req,
    input  logic [IP_WIDTH-1:0]       lpm_wr_ip,
    input  logic [IP_WIDTH-1:0]       lpm_wr_mask,
    input  logic [IP_WIDTH-1:0]       lpm_wr_next_hop_ip,
    input  logic [NUM_QUEUES-1:0]     lpm_wr_output_port,
    output logic                      lpm_wr_ack
);

    logic [IP_WIDTH-1:0]       lut_ip   [LUT_DEPTH];
    logic [IP_WIDTH-1:0]       lut_mask [LUT_DEPTH];
    logic [IP_WIDTH-1:0]       lut_nh   [LUT_DEPTH];
    logic [NUM_QUEUES-1:0]     lut_port [LUT_DEPTH];

    logic [LUT_DEPTH-1:0]      match_vec;
    logic [LUT_DEPTH-1:0]      match_s1;
    logic [IP_WIDTH-1:0]       dst_ip_s1;
    logic                      vld_s1;

    logic [IP_WIDTH-1:0]       rd_sel_ip;
    logic [IP_WIDTH-1:0]       rd_sel_mask;
    logic [IP_WIDTH-1:0]       rd_sel_nh;
    logic [NUM_QUEUES-1:0]     rd_sel_port;
    logic [IP_WIDTH-1:0]       wr_old_nh;
    logic [NUM_QUEUES-1:0]     wr_old_port;

    logic                      wr_s1;
    logic [LUT_DEPTH_BITS-1:0] wr_addr_s1;
    logic [IP_WIDTH-1:0]       wr_old_nh_s1;
    logic [NUM_QUEUES-1:0]     wr_old_port_s1;

    logic [LUT_DEPTH_BITS-1:0] win_idx;
    logic                      win_found;
    logic [IP_WIDTH-1:0]       win_nh;
    logic [NUM_QUEUES-1:0]     win_port;

    // Address decode by comparison, so an out-of-range index simply selects nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_ip[i]   <= '0;
                lut_mask[i] <= '0;
                lut_nh[i]   <= '0;
                lut_port[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                if (lpm_wr_req && (lpm_wr_addr == LUT_DEPTH_BITS'(i))) begin
                    lut_ip[i]   <= lpm_wr_ip;
                    lut_mask[i] <= lpm_wr_mask;
                    lut_nh[i]   <= lpm_wr_next_hop_ip;
                    lut_port[i] <= lpm_wr_output_port;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LUT_DEPTH; i++) begin
            match_vec[i] = (lut_port[i] != '0) &&
                           prefix_match(dst_ip, lut_ip[i], lut_mask[i]);
        end
    end

    // Pre-write contents of the read and write targets.
    always_comb begin
        rd_sel_ip   = '0;
        rd_sel_mask = '0;
        rd_sel_nh   = '0;
        rd_sel_port = '0;
        wr_old_nh   = '0;
        wr_old_port = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (lpm_rd_addr == LUT_DEPTH_BITS'(i)) begin
                rd_sel_ip   = lut_ip[i];
                rd_sel_mask = lut_mask[i];
                rd_sel_nh   = lut_nh[i];
                rd_sel_port = lut_port[i];
            end
            if (lpm_wr_addr == LUT_DEPTH_BITS'(i)) begin
                wr_old_nh   = lut_nh[i];
                wr_old_port = lut_port[i];
            end
        end
    end

    // The old result fields of a just-written entry travel with stage 1 so a
    // lookup keeps seeing the table as it was on its strobe cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_s1         <= 1'b0;
            match_s1       <= '0;
            dst_ip_s1      <= '0;
            wr_s1          <= 1'b0;
            wr_addr_s1     <= '0;
            wr_old_nh_s1   <= '0;
            wr_old_port_s1 <= '0;
        end else begin
            vld_s1         <= dst_ip_vld;
            match_s1       <= match_vec;
            dst_ip_s1      <= dst_ip;
            wr_s1          <= lpm_wr_req;
            wr_addr_s1     <= lpm_wr_addr;
            wr_old_nh_s1   <= wr_old_nh;
            wr_old_port_s1 <= wr_old_port;
        end
    end

    lpm_prio_enc #(
        .WIDTH    (LUT_DEPTH),
        .IDX_BITS (LUT_DEPTH_BITS)
    ) u_prio_enc (
        .req   (match_s1),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        win_nh   = '0;
        win_port = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (win_idx == LUT_DEPTH_BITS'(i)) begin
                win_nh   = lut_nh[i];
                win_port = lut_port[i];
            end
        end
        if (wr_s1 && (wr_addr_s1 == win_idx)) begin
            win_nh   = wr_old_nh_s1;
            win_port = wr_old_port_s1;
        end
    end

    // Result fields only update on a valid lookup; a zero next hop means directly connected.
    always_ff @(posedge clk) begin
        if (reset) begin
            lpm_vld         <= 1'b0;
            lpm_hit         <= 1'b0;
            next_hop_ip     <= '0;
            lpm_output_port <= '0;
        end else begin
            lpm_vld <= vld_s1;
            if (vld_s1) begin
                lpm_hit         <= win_found;
                lpm_output_port <= win_found ? win_port : '0;
                next_hop_ip     <= (win_found && (win_nh != '0)) ? win_nh : dst_ip_s1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lpm_rd_ack         <= 1'b0;
            lpm_wr_ack         <= 1'b0;
            lpm_rd_ip          <= '0;
            lpm_rd_mask        <= '0;
            lpm_rd_next_hop_ip <= '0;
            lpm_rd_output_port <= '0;
        end else begin
            lpm_rd_ack <= lpm_rd_req;
            lpm_wr_ack <= lpm_wr_req;
            if (lpm_rd_req) begin
                lpm_rd_ip          <= rd_sel_ip;
                lpm_rd_mask        <= rd_sel_mask;
                lpm_rd_next_hop_ip <= rd_sel_nh;
                lpm_rd_output_port <= rd_sel_port;
            end
        end
    end

endmodule

// File: doc/ip_lpm.md
Name: ip_lpm

Overview:
- Longest-prefix-match route lookup stage in the router output-port-lookup pipeline.
- Directly upstream of the ARP lookup stage: takes the destination IPv4 address parsed from the packet and produces the next-hop IP, the output-port one-hot vector and the hit flag.
- Its outputs are next_hop_ip, lpm_output_port, lpm_vld and lpm_hit, consumed by the ARP lookup stage.
- Route table is a register-resident array, software-managed through a read/write port with acks.
- Software keeps entries ordered longest prefix first; lowest matching index wins.

Parameters:
NUM_QUEUES, 8, width of the one-hot output-port vector.
LUT_DEPTH, 32, number of route-table entries.
LUT_DEPTH_BITS, log2(LUT_DEPTH), route-table address width.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
dst_ip  in  32  destination IP to look up.
dst_ip_vld  in  1  one-cycle strobe; dst_ip valid this cycle.
next_hop_ip  out  32  next-hop IP of the winning entry.
lpm_output_port  out  NUM_QUEUES  output-port vector of the winning entry.
lpm_vld  out  1  one-cycle strobe; result valid this cycle.
lpm_hit  out  1  an entry matched.
lpm_rd_addr  in  LUT_DEPTH_BITS  table read index.
lpm_rd_req  in  1  read request strobe.
lpm_rd_ip  out  32  entry prefix.
lpm_rd_mask  out  32  entry mask.
lpm_rd_next_hop_ip  out  32  entry next hop.
lpm_rd_output_port  out  NUM_QUEUES  entry port vector.
lpm_rd_ack  out  1  one-cycle pulse; read data valid.
lpm_wr_addr  in  LUT_DEPTH_BITS  table write index.
lpm_wr_req  in  1  write request strobe.
lpm_wr_ip  in  32  prefix to store.
lpm_wr_mask  in  32  mask to store.
lpm_wr_next_hop_ip  in  32  next hop to store.
lpm_wr_output_port  in  NUM_QUEUES  port vector to store.
lpm_wr_ack  out  1  one-cycle pulse; write committed.

Behaviour:
- **Reset:**
  - All table fields are 0.
  - lpm_vld, lpm_hit, lpm_rd_ack and lpm_wr_ack are 0.
  - next_hop_ip, lpm_output_port and all lpm_rd_* data are 0.
- **Empty entry:** an entry with output_port == 0 is empty and never matches. After reset every entry is empty.
- **Match:** entry i matches when it is not empty and (dst_ip & mask_i) == (ip_i & mask_i). mask_i == 0 gives a default route.
- **Pipeline:** 2 stages, fully pipelined, one lookup accepted per cycle, no backpressure. The downstream ARP FIFO absorbs bursts; the upstream stage limits the rate.
  - Stage 1 (registered at t+1): LUT_DEPTH-bit match vector, dst_ip and valid.
  - Stage 2 (registered at t+2): priority-encode the lowest set bit, mux that entry's fields, drive the outputs.
- **Latency:** dst_ip_vld at cycle t gives lpm_vld = 1 at t+2 for exactly one cycle.
- **Outputs on hit:**
  - lpm_hit = 1 and lpm_output_port = the entry's port vector.
  - next_hop_ip = the entry's next hop, or dst_ip if the entry's next hop is 0 (directly connected).
- **Outputs on miss:** lpm_hit = 0, lpm_output_port = 0, next_hop_ip = dst_ip.
- **Output hold:** when lpm_vld = 0, next_hop_ip, lpm_output_port and lpm_hit hold their last values. Consumers qualify them with lpm_vld.
- **Write:**
  - lpm_wr_req at t commits all four fields at the end of t.
  - lpm_wr_ack = 1 at t+1.
  - A lookup strobed at t sees the old table; a lookup strobed at t+1 sees the new one.
- **Read:**
  - lpm_rd_req at t latches the entry at t; lpm_rd_ack = 1 at t+1 with data.
  - lpm_rd_* data holds until the next read.
  - Read and write to the same address in the same cycle: the read returns the pre-write contents.
  - Simultaneous read and write to different addresses: both are serviced; both acks fire at t+1.
- **Back-to-back requests:** a request may be issued every cycle; each produces its own ack pulse.
- **Reset mid-operation:**
  - In-flight lookups are discarded; no lpm_vld is issued for them.
  - Pending acks are dropped.
  - The table is cleared.
- **Out-of-range addresses:** when LUT_DEPTH is not a power of two, an address ≥ LUT_DEPTH is ignored on write and reads back zeros. The ack is still issued.

Decomposition:
- Shared package: route-entry field widths (IP_WIDTH = 32) and the entry record layout {ip, mask, next_hop_ip, output_port}. Also reused by the register-block glue.
- One sub-module: lpm_prio_enc. Parameterised LUT_DEPTH-to-LUT_DEPTH_BITS lowest-index priority encoder with a found flag, purely combinational, instantiated in stage 2.

Test Plan:
1. After reset, dst_ip=0x0A000001 strobed at t → at t+2: lpm_vld=1, lpm_hit=0, lpm_output_port=0, next_hop_ip=0x0A000001. lpm_vld is 0 at t+1 and t+3.
2. Write entry 0 {ip=0xC0A80100, mask=0xFFFFFF00, nh=0, port=0x04} and entry 1 {ip=0, mask=0, nh=0x0A000001, port=0x01}; lpm_wr_ack each one cycle after req. Lookups:
   - 0xC0A80105 → hit, port=0x04, next_hop_ip=0xC0A80105.
   - 0x08080808 → hit, port=0x01, next_hop_ip=0x0A000001.
3. Lookups strobed on 4 consecutive cycles, alternating 0xC0A80105 and 0x08080808 → lpm_vld on 4 consecutive cycles, results in order, each 2 cycles after its strobe.
4. Write to entry 1 and lookup 0x08080808 in the same cycle t, with entry 1 changed to port=0x10 → lookup at t returns port 0x01; repeat at t+1 → port 0x10.
5. Read entry 0 → lpm_rd_ack at t+1 with {0xC0A80100, 0xFFFFFF00, 0, 0x04}. Same-cycle read and write of entry 0 → read returns the old contents, both acks at t+1.
6. Reset asserted the cycle after a dst_ip_vld → no lpm_vld issued; a subsequent lookup misses (table cleared).
